// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives word addresses into a 1-cycle clocked imem and buffers
// {pc, inst} in a 2-entry FIFO; credit-limited issue so decode stalls never drop or duplicate words.

// Small generic FIFO with synchronous flush; count/head are registered, no bypass.
// Caller guarantees no push when full and no pop when empty.
module if_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic [W-1:0]                 push_dat,
   input  logic                         pop,
   output logic [W-1:0]                 head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_dat = mem[rd_ptr];

endmodule

// Fetch unit: one instruction per cycle when decode is ready; first valid 2 edges after reset/redirect.
// Backpressure via out_ready; issue stops once buffered + in-flight words would exceed 2.
module instr_fetch #(
   parameter int          ADDR_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [1:0]        count;
   logic [ADDR_W-1:0] head_pc;
   logic [31:0]       head_inst;
   logic              pop;
   logic              issue;
   logic [2:0]        occupancy;
   logic              unused_redirect_hi;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;

   // A word in flight already owns a buffer slot; a pop this edge frees one.
   assign occupancy = {1'b0, count} + {2'b0, inflight};
   assign issue     = en & ~redirect_valid & (occupancy < (3'd2 + {2'b0, pop}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= ADDR_W'(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc[ADDR_W-1:0];
         inflight <= 1'b0;
      end else if (issue) begin
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
         fetch_pc    <= fetch_pc + ADDR_W'(1);
      end else begin
         inflight <= 1'b0;
      end
   end

   // Redirect discards the returning wrong-path word and any pop on the same edge.
   if_fifo #(
      .W     (ADDR_W + 32),
      .DEPTH (2)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (inflight & ~redirect_valid),
      .push_dat ({inflight_pc, imem_inst}),
      .pop      (pop & ~redirect_valid),
      .head_dat ({head_pc, head_inst}),
      .count    (count)
   );

   assign imem_addr = {{(32 - ADDR_W){1'b0}}, fetch_pc};
   assign out_pc    = {{(32 - ADDR_W){1'b0}}, head_pc};
   assign out_inst  = head_inst;

   assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];

endmodule
